// File: rtl/dsp_arith_pkg.sv
// rtl/dsp_arith_pkg.sv - shared arithmetic constants and FSM encoding for the sequential DSP blocks
package dsp_arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CAL  = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CAL  = ST_CAL,
    S_FIX  = ST_FIX
  } div_state_e;

  localparam int DIV_DIVIDEND_W = 32;
  localparam int DIV_DIVISOR_W  = 16;
  localparam int DIV_ITERS      = 32;
  localparam int DIV_CNT_W      = 6;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration on unsigned magnitudes
module div_step
  import dsp_arith_pkg::*;
#(
  parameter int QW = DIV_DIVIDEND_W,
  parameter int DW = DIV_DIVISOR_W
) (
  input  logic [DW-1:0] r,
  input  logic [QW-1:0] q,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] r_next,
  output logic [QW-1:0] q_next
);

  logic [DW:0] r_sh;
  logic        ge;

  // Partial remainder stays below |d| between steps, so only the shifted value needs the extra bit.
  always_comb begin
    r_sh   = {r, q[QW-1]};
    ge     = (r_sh >= {1'b0, d});
    r_next = ge ? DW'(r_sh - {1'b0, d}) : r_sh[DW-1:0];
    q_next = {q[QW-2:0], ge};
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential signed divider, one restoring step per cycle, start/done handshake
module seq_divider
  import dsp_arith_pkg::*;
#(
  parameter int din0_WIDTH = DIV_DIVIDEND_W,
  parameter int din1_WIDTH = DIV_DIVISOR_W,
  parameter int dout_WIDTH = DIV_DIVIDEND_W
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  start,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_zero,
  output logic                  busy,
  output logic                  done
);

  localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(din0_WIDTH - 1);

  div_state_e            state;
  logic [DIV_CNT_W-1:0]  step_cnt;
  logic [din0_WIDTH-1:0] q_r, q_nx;
  logic [din1_WIDTH-1:0] r_r, r_nx, dmag_r;
  logic                  sq_r, sr_r, dz_r;

  div_step #(
    .QW(din0_WIDTH),
    .DW(din1_WIDTH)
  ) u_step (
    .r     (r_r),
    .q     (q_r),
    .d     (dmag_r),
    .r_next(r_nx),
    .q_next(q_nx)
  );

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state    <= S_IDLE;
      step_cnt <= '0;
      q_r      <= '0;
      r_r      <= '0;
      dmag_r   <= '0;
      sq_r     <= 1'b0;
      sr_r     <= 1'b0;
      dz_r     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // Negating -2^N wraps to 2^N, which is still correct read as unsigned.
            q_r      <= din0[din0_WIDTH-1] ? -din0 : din0;
            dmag_r   <= din1[din1_WIDTH-1] ? -din1 : din1;
            sq_r     <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
            sr_r     <= din0[din0_WIDTH-1];
            dz_r     <= (din1 == '0);
            r_r      <= '0;
            step_cnt <= '0;
            busy     <= 1'b1;
            state    <= S_CAL;
          end
        end
        S_CAL: begin
          q_r      <= q_nx;
          r_r      <= r_nx;
          step_cnt <= step_cnt + 1'b1;
          if (step_cnt == LAST_STEP) state <= S_FIX;
        end
        S_FIX: begin
          if (dz_r) begin
            quot <= '1;
            rem  <= '0;
          end else begin
            quot <= dout_WIDTH'(sq_r ? -q_r : q_r);
            rem  <= sr_r ? -r_r : r_r;
          end
          div_zero <= dz_r;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider with directed vectors
module tb_seq_divider;

  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic [31:0] din0     = '0;
  logic [15:0] din1     = '0;
  logic        start    = 1'b0;
  logic [31:0] quot;
  logic [15:0] rem;
  logic        div_zero;
  logic        busy;
  logic        done;

  seq_divider dut (
    .axis_clk(axis_clk),
    .axis_rst(axis_rst),
    .din0    (din0),
    .din1    (din1),
    .start   (start),
    .quot    (quot),
    .rem     (rem),
    .div_zero(div_zero),
    .busy    (busy),
    .done    (done)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        dz;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          passes = 0;
  int unsigned cyc    = 0;
  logic        prev_done = 1'b0;

  always @(posedge axis_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge axis_clk) begin
    if (done) begin
      check("done_single_cycle", prev_done, 0);
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done with quot %0h, expected no result pending", quot);
      end else begin
        e = sb.pop_front();
        check({e.name, "_quot"}, quot, e.q);
        check({e.name, "_rem"}, rem, e.r);
        check({e.name, "_div_zero"}, div_zero, e.dz);
        check({e.name, "_latency"}, cyc, e.cyc);
      end
    end
    prev_done = done;
  end

  task automatic push(input logic [31:0] q, input logic [15:0] r, input logic dz, input string nm);
    sb.push_back('{q, r, dz, cyc + 34, nm});
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 80) begin
      @(negedge axis_clk);
      n++;
    end
    if (!done) begin
      checks++;
      $display("FAIL %s_timeout: got no done in 80 cycles, expected done", nm);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [15:0] b, input logic [31:0] eq,
                       input logic [15:0] er, input logic edz, input string nm, input bit poke);
    @(negedge axis_clk);
    din0  = a;
    din1  = b;
    start = 1'b1;
    push(eq, er, edz, nm);
    @(negedge axis_clk);
    start = 1'b0;
    check({nm, "_busy"}, busy, 1);
    if (poke) begin
      repeat (5) @(negedge axis_clk);
      din0  = 32'h0BAD_0BAD;
      din1  = 16'h0003;
      start = 1'b1;
      @(negedge axis_clk);
      start = 1'b0;
    end
    @(negedge axis_clk);
    wait_done(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge axis_clk);
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    axis_rst = 1'b0;

    issue(32'd100,        16'd7,      32'd14,        16'd2,      1'b0, "p100_7",  1'b1);
    issue(32'hFFFF_FF9C,  16'd7,      32'hFFFF_FFF2, 16'hFFFE,   1'b0, "n100_7",  1'b0);
    issue(32'd100,        16'hFFF9,   32'hFFFF_FFF2, 16'd2,      1'b0, "p100_n7", 1'b1);
    issue(32'hFFFF_FFF9,  16'hFFFE,   32'd3,         16'hFFFF,   1'b0, "n7_n2",   1'b0);
    issue(32'd12345,      16'd0,      32'hFFFF_FFFF, 16'h0000,   1'b1, "dz",      1'b0);
    issue(32'd6,          16'd3,      32'd2,         16'd0,      1'b0, "p6_3",    1'b0);
    issue(32'h8000_0000,  16'hFFFF,   32'h8000_0000, 16'd0,      1'b0, "ovf",     1'b0);
    issue(32'h7FFF_FFFF,  16'h8000,   32'hFFFF_0001, 16'h7FFF,   1'b0, "max_min", 1'b0);

    // start held high: operands change mid-op, next op sampled the cycle after done.
    @(negedge axis_clk);
    din0 = 32'd1000; din1 = 16'd10; start = 1'b1;
    push(32'd100, 16'd0, 1'b0, "bb1");
    repeat (5) @(negedge axis_clk);
    din0 = 32'h1234_5678; din1 = 16'd1;
    wait_done("bb1");
    din0 = 32'hFFFF_FFB3; din1 = 16'd4;
    push(32'hFFFF_FFED, 16'hFFFF, 1'b0, "bb2");
    repeat (5) @(negedge axis_clk);
    din0 = 32'h0000_0001; din1 = 16'd0;
    wait_done("bb2");
    din0 = 32'd65536; din1 = 16'hFFFD;
    push(32'hFFFF_AAAB, 16'd1, 1'b0, "bb3");
    repeat (5) @(negedge axis_clk);
    din0 = 32'd9; din1 = 16'd9;
    wait_done("bb3");
    start = 1'b0;

    // Abort after CAL step 10.
    @(negedge axis_clk);
    din0 = 32'd1000; din1 = 16'd3; start = 1'b1;
    @(negedge axis_clk);
    start = 1'b0;
    repeat (10) @(negedge axis_clk);
    axis_rst = 1'b1;
    @(negedge axis_clk);
    check("abort_quot", quot, 0);
    check("abort_rem", rem, 0);
    check("abort_div_zero", div_zero, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    axis_rst = 1'b0;
    repeat (40) @(negedge axis_clk);
    check("abort_idle_busy", busy, 0);

    issue(32'd50, 16'd5, 32'd10, 16'd0, 1'b0, "p50_5", 1'b0);

    repeat (3) @(negedge axis_clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
